// File: rtl/pixel_read_seq.sv
// pixel_read_seq: claims the SRAM clock, reads an address window and streams it out as valid/ready pixels
module pixel_read_seq #(
  parameter int DW     = 64,
  parameter int AW     = 9,
  parameter int SW_CYC = 4
) (
  input  logic          clk_p,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [AW-1:0] base_addr_i,
  input  logic [AW:0]   len_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          pixel_trigger_o,
  output logic          pixel_trigger_done_o,
  output logic          rd_o,
  output logic [AW-1:0] addr_rd_o,
  input  logic [DW-1:0] sram_data_i,
  output logic          pix_valid_o,
  output logic [DW-1:0] pix_data_o,
  output logic          pix_last_o,
  input  logic          pix_ready_i
);
  typedef enum logic [2:0] {IDLE, SWITCH, READ, DRAIN, DONE} state_t;
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};
  state_t        state, state_nx;
  logic [3:0]    sw_cnt;
  logic [AW:0]   len_sat, last_idx, issued, accepted;
  logic [AW-1:0] base_q, addr_q;
  logic          nz_q, inflight, wr_ptr, rd_ptr, pop;
  logic [1:0]    fifo_cnt, occ;
  logic [DW-1:0] fifo_mem [2];
  always_comb begin
    len_sat              = len_i > DEPTH ? DEPTH : len_i;
    pix_valid_o          = fifo_cnt != 2'd0;
    pop                  = pix_valid_o && pix_ready_i;
    occ                  = fifo_cnt + 2'(inflight) - 2'(pop);
    pix_data_o           = pix_valid_o ? fifo_mem[rd_ptr] : '0;
    pix_last_o           = pix_valid_o && accepted == last_idx;
    rd_o                 = state == READ && occ < 2'd2;
    addr_rd_o            = rd_o ? base_q + issued[AW-1:0] : addr_q;
    busy_o               = state != IDLE;
    done_o               = state == DONE;
    pixel_trigger_o      = state == SWITCH || state == READ || state == DRAIN;
    pixel_trigger_done_o = done_o && nz_q;
    state_nx             = state;
    unique case (state)
      IDLE:    if (start_i) state_nx = len_sat == '0 ? DONE : SWITCH;
      SWITCH:  if (sw_cnt == 4'(SW_CYC - 1)) state_nx = READ;
      READ:    if (rd_o && issued == last_idx) state_nx = DRAIN;
      DRAIN:   if (pop && accepted == last_idx) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_p or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      sw_cnt      <= '0;
      base_q      <= '0;
      last_idx    <= '0;
      nz_q        <= 1'b0;
      issued      <= '0;
      accepted    <= '0;
      addr_q      <= '0;
      inflight    <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= '0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      sw_cnt <= state == SWITCH ? sw_cnt + 4'd1 : 4'd0;
      if (state == IDLE && start_i) begin
        base_q   <= base_addr_i;
        last_idx <= len_sat - ONE;
        nz_q     <= len_sat != '0;
        issued   <= '0;
        accepted <= '0;
      end else begin
        issued   <= issued + (AW+1)'(rd_o);
        accepted <= accepted + (AW+1)'(pop);
      end
      addr_q   <= addr_rd_o;
      inflight <= rd_o;
      if (inflight) begin
        fifo_mem[wr_ptr] <= sram_data_i;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + 2'(inflight) - 2'(pop);
    end
  end
endmodule

// File: tb/tb_pixel_read_seq.sv
// tb_pixel_read_seq: randomized and directed checks of pixel_read_seq against a transaction-level model
module tb_pixel_read_seq;
  localparam int DW = 64, AW = 9, SW = 4;
  logic clk_p = 1'b0, rst_n = 1'b0, start_i = 1'b0, pix_ready_i = 1'b1;
  logic [AW-1:0] base_addr_i = '0;
  logic [AW:0] len_i = '0;
  logic busy_o, done_o, pixel_trigger_o, pixel_trigger_done_o, rd_o, pix_valid_o, pix_last_o;
  logic [AW-1:0] addr_rd_o;
  logic [DW-1:0] sram_data_i = '0, pix_data_o;
  logic [DW-1:0] mem [512];
  int tests = 0, fails = 0, cyc = 0, ts = 0;
  bit rnd_ready = 1'b0, stall_arm = 1'b0;
  int stall_left = 0;
  // model state
  bit m_act = 1'b0;
  int m_t0 = 0, m_n = 0, m_base = 0, m_rds = 0, m_acc = 0, m_done_c = -1;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] q_dat[$];
  int q_av[$], q_idx[$];
  bit v, pop, rdx, dn;
  int occ;
  // observation logs
  int rd_cyc[$], beat_cyc[$];
  logic [AW-1:0] rd_adr[$];
  logic [DW-1:0] beat_dat[$];
  bit beat_last[$];
  int done_cnt = 0, tdone_cnt = 0, trig_cnt = 0, done_cyc = 0;

  pixel_read_seq #(.DW(DW), .AW(AW), .SW_CYC(SW)) dut (
    .clk_p(clk_p), .rst_n(rst_n), .start_i(start_i), .base_addr_i(base_addr_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .pixel_trigger_o(pixel_trigger_o),
    .pixel_trigger_done_o(pixel_trigger_done_o), .rd_o(rd_o), .addr_rd_o(addr_rd_o),
    .sram_data_i(sram_data_i), .pix_valid_o(pix_valid_o), .pix_data_o(pix_data_o),
    .pix_last_o(pix_last_o), .pix_ready_i(pix_ready_i)
  );

  always #5 clk_p = ~clk_p;
  always @(posedge clk_p) cyc <= cyc + 1;
  always @(posedge clk_p) if (rd_o) sram_data_i <= mem[addr_rd_o];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", nm, cyc, act, exp);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial forever begin
    @(posedge clk_p); #1;
    if (stall_arm && pix_valid_o) begin
      stall_left = 10;
      stall_arm = 1'b0;
    end
    if (stall_left > 0) begin
      pix_ready_i = 1'b0;
      stall_left--;
    end else pix_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial forever begin
    @(negedge clk_p);
    if (!rst_n) begin
      m_act = 1'b0;
      m_addr = '0;
      q_dat.delete(); q_av.delete(); q_idx.delete();
    end else begin
      v = q_dat.size() > 0 && q_av[0] <= cyc;
      pop = v && pix_ready_i;
      occ = m_rds - m_acc - (pop ? 1 : 0);
      rdx = m_act && m_n > 0 && cyc >= m_t0 + SW + 1 && m_rds < m_n && occ < 2;
      dn = m_act && cyc == m_done_c;
      chk("busy", busy_o, m_act);
      chk("done", done_o, dn);
      chk("trigger", pixel_trigger_o, m_act && !dn && m_n > 0);
      chk("trigger_done", pixel_trigger_done_o, dn && m_n > 0);
      chk("rd", rd_o, rdx);
      chk("addr", addr_rd_o, rdx ? AW'(m_base + m_rds) : m_addr);
      chk("valid", pix_valid_o, v);
      if (v) begin
        chk("data", pix_data_o, q_dat[0]);
        chk("last", pix_last_o, q_idx[0] == m_n - 1);
      end
      if (rd_o) begin rd_cyc.push_back(cyc); rd_adr.push_back(addr_rd_o); end
      if (pix_valid_o && pix_ready_i) begin
        beat_cyc.push_back(cyc); beat_dat.push_back(pix_data_o); beat_last.push_back(pix_last_o);
      end
      if (done_o) begin done_cnt++; done_cyc = cyc; end
      if (pixel_trigger_done_o) tdone_cnt++;
      if (pixel_trigger_o) trig_cnt++;
      if (rdx) begin
        q_dat.push_back(mem[(m_base + m_rds) % 512]);
        q_av.push_back(cyc + 2);
        q_idx.push_back(m_rds);
        m_addr = AW'(m_base + m_rds);
        m_rds++;
      end
      if (pop) begin
        void'(q_dat.pop_front()); void'(q_av.pop_front()); void'(q_idx.pop_front());
        m_acc++;
        if (m_acc == m_n) m_done_c = cyc + 1;
      end
      if (dn) m_act = 1'b0;
      else if (!m_act && start_i) begin
        m_act = 1'b1;
        m_t0 = cyc;
        m_n = len_i > 512 ? 512 : int'(len_i);
        m_base = int'(base_addr_i);
        m_rds = 0;
        m_acc = 0;
        m_done_c = m_n == 0 ? cyc + 1 : -1;
      end
    end
  end

  task automatic clear_logs();
    rd_cyc.delete(); rd_adr.delete(); beat_cyc.delete(); beat_dat.delete(); beat_last.delete();
    done_cnt = 0; tdone_cnt = 0; trig_cnt = 0;
  endtask

  task automatic launch(input logic [AW-1:0] b, input logic [AW:0] l);
    clear_logs();
    @(posedge clk_p); #1;
    base_addr_i = b; len_i = l; start_i = 1'b1; ts = cyc;
    @(posedge clk_p); #1;
    start_i = 1'b0; base_addr_i = AW'($urandom); len_i = (AW+1)'($urandom);
  endtask

  task automatic finish_xfer(input bit poke, input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) begin
      if (poke && busy_o && !done_o && (rd_adr.size() == 3 || $urandom_range(0, 7) == 0)) begin
        start_i = 1'b1; len_i = (AW+1)'($urandom); base_addr_i = AW'($urandom);
      end
      @(posedge clk_p); #1;
      start_i = 1'b0;
    end
    chk("complete", done_cnt > 0, 1'b1);
    repeat (2) @(posedge clk_p);
    #1;
  endtask

  task automatic xfer(input logic [AW-1:0] b, input logic [AW:0] l, input bit poke);
    launch(b, l);
    finish_xfer(poke, 4 * (l > 512 ? 512 : int'(l)) + 100);
  endtask

  initial begin
    logic [AW-1:0] wexp [4];
    int wraps;
    wexp = '{9'h1FE, 9'h1FF, 9'h000, 9'h001};
    foreach (mem[i]) mem[i] = {32'hC0DE0000 + 32'(i), 32'($urandom)};
    repeat (3) @(posedge clk_p);
    #1;
    chk("rst_busy", busy_o, 1'b0); chk("rst_rd", rd_o, 1'b0); chk("rst_valid", pix_valid_o, 1'b0);
    chk("rst_done", done_o, 1'b0); chk("rst_trig", pixel_trigger_o, 1'b0); chk("rst_addr", addr_rd_o, 9'h0);
    rst_n = 1'b1;
    // basic window
    xfer(9'h010, 10'd4, 1'b0);
    chk("t1_nrd", rd_adr.size(), 4);
    chk("t1_nbeat", beat_dat.size(), 4);
    if (rd_cyc.size() > 0) chk("t1_first_rd_lat", rd_cyc[0] - ts, 5);
    for (int k = 0; k < 4 && k < rd_adr.size() && k < beat_dat.size(); k++) begin
      chk("t1_addr", rd_adr[k], 9'h010 + 9'(k));
      chk("t1_rd_consec", rd_cyc[k] - rd_cyc[0], k);
      chk("t1_beat_lat", beat_cyc[k] - rd_cyc[k], 2);
      chk("t1_data", beat_dat[k][63:32], 32'hC0DE0010 + 32'(k));
      chk("t1_last", beat_last[k], k == 3);
    end
    chk("t1_done_cnt", done_cnt, 1); chk("t1_tdone_cnt", tdone_cnt, 1);
    chk("t1_idle", busy_o, 1'b0);
    // address wrap
    xfer(9'h1FE, 10'd4, 1'b0);
    chk("t2_nrd", rd_adr.size(), 4);
    for (int k = 0; k < 4 && k < rd_adr.size() && k < beat_dat.size(); k++) begin
      chk("t2_addr", rd_adr[k], wexp[k]);
      chk("t2_data", beat_dat[k][63:32], 32'hC0DE0000 + 32'(wexp[k]));
    end
    // downstream stall
    stall_arm = 1'b1;
    xfer(9'h080, 10'd6, 1'b0);
    chk("t3_nbeat", beat_dat.size(), 6);
    if (beat_cyc.size() > 0) begin
      wraps = 0;
      foreach (rd_cyc[k]) if (rd_cyc[k] < beat_cyc[0]) wraps++;
      chk("t3_reads_before_accept", wraps, 2);
    end
    for (int k = 0; k < beat_dat.size(); k++) chk("t3_data", beat_dat[k][63:32], 32'hC0DE0080 + 32'(k));
    // zero length
    xfer(9'h033, 10'd0, 1'b0);
    chk("t4_done_lat", done_cyc - ts, 1); chk("t4_nrd", rd_adr.size(), 0);
    chk("t4_trig", trig_cnt, 0); chk("t4_tdone", tdone_cnt, 0); chk("t4_done_cnt", done_cnt, 1);
    // reset mid-READ
    launch(9'h040, 10'd8);
    for (int i = 0; i < 50 && rd_adr.size() < 3; i++) begin @(posedge clk_p); #1; end
    chk("t5_reached_read", rd_adr.size() >= 3, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_busy", busy_o, 1'b0); chk("t5_done", done_o, 1'b0); chk("t5_trig", pixel_trigger_o, 1'b0);
    chk("t5_tdone", pixel_trigger_done_o, 1'b0); chk("t5_rd", rd_o, 1'b0); chk("t5_addr", addr_rd_o, 9'h0);
    chk("t5_valid", pix_valid_o, 1'b0); chk("t5_data", pix_data_o, 64'h0); chk("t5_last", pix_last_o, 1'b0);
    repeat (3) @(posedge clk_p);
    #1 rst_n = 1'b1;
    chk("t5_no_done", done_cnt, 0);
    xfer(9'h100, 10'd2, 1'b0);
    chk("t5_after_nbeat", beat_dat.size(), 2); chk("t5_after_done", done_cnt, 1);
    // saturation, wrap, ignored start
    xfer(9'h100, 10'd600, 1'b1);
    chk("t6_nrd", rd_adr.size(), 512); chk("t6_nbeat", beat_dat.size(), 512);
    wraps = 0;
    for (int k = 1; k < rd_adr.size(); k++) if (rd_adr[k] < rd_adr[k-1]) wraps++;
    chk("t6_wraps", wraps, 1); chk("t6_done_cnt", done_cnt, 1);
    // randomized
    rnd_ready = 1'b1;
    for (int t = 0; t < 24; t++) begin
      int l;
      l = t % 12 == 5 ? $urandom_range(480, 700) : (t % 7 == 3 ? 0 : $urandom_range(1, 20));
      if (t % 5 == 2) stall_arm = 1'b1;
      xfer(AW'($urandom), (AW+1)'(l), 1'b1);
      chk("rnd_nbeat", beat_dat.size(), l > 512 ? 512 : l);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
